// File: rtl/paint_tracker_grid.sv
// Cursor-driven paint grid: button edges move a cursor over a fine and a coarse
// bitmap, visited cells latch "painted", and a per-pixel bit plus painted-pixel count are supplied.
module paint_tracker_grid #(
  parameter int HSIZE   = 96,
  parameter int VSIZE   = 54,
  parameter int CELL_PX = 5,
  parameter int WRAP    = 0,
  parameter int CNT_W   = 17
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       PushButton,
  input  logic             SW,
  input  logic [11:0]      hcnt,
  input  logic [11:0]      vcnt,
  output logic             on,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic             busy,
  output logic [8:0]       cur_row,
  output logic [8:0]       cur_col
);
  localparam int CH  = HSIZE / 2;
  localparam int CV  = VSIZE / 2;
  localparam int FRW = $clog2(VSIZE);
  localparam int FCW = $clog2(HSIZE);
  localparam int CRW = $clog2(CV);
  localparam int CCW = $clog2(CH);
  localparam logic [CNT_W-1:0] FINE_INC   = CNT_W'(CELL_PX * CELL_PX);
  localparam logic [CNT_W-1:0] COARSE_INC = CNT_W'(4 * CELL_PX * CELL_PX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [HSIZE-1:0] fine_q   [VSIZE];
  logic [HSIZE-1:0] fine_d   [VSIZE];
  logic [CH-1:0]    coarse_q [CV];
  logic [CH-1:0]    coarse_d [CV];
  logic [4:0]       prev_q;
  logic [8:0]       row_q, row_d, col_q, col_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             on_q, on_d;
  logic [FRW-1:0]   sweep_q, sweep_d;
  logic [CNT_W-1:0] fine_cnt_q, fine_cnt_d;
  logic [CNT_W-1:0] coarse_cnt_q, coarse_cnt_d;
  logic [4:0]       btn_edge;
  logic [8:0]       hlim, vlim;
  logic             in_range;
  logic [11:0]      fy, fx, cy, cx;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > CNT_MAX - b) ? CNT_MAX : a + b;
  endfunction

  always_comb begin
    btn_edge     = PushButton & ~prev_q;
    hlim         = SW ? 9'(CH) : 9'(HSIZE);
    vlim         = SW ? 9'(CV) : 9'(VSIZE);
    in_range     = (row_q < vlim) && (col_q < hlim);
    fine_d       = fine_q;
    coarse_d     = coarse_q;
    row_d        = row_q;
    col_d        = col_q;
    armed_d      = armed_q;
    busy_d       = busy_q;
    sweep_d      = sweep_q;
    fine_cnt_d   = fine_cnt_q;
    coarse_cnt_d = coarse_cnt_q;
    if (btn_edge[4]) begin
      row_d        = '0;
      col_d        = '0;
      armed_d      = 1'b0;
      fine_cnt_d   = '0;
      coarse_cnt_d = '0;
      busy_d       = 1'b1;
      sweep_d      = FRW'(VSIZE - 1);
    end else if (busy_q) begin
      // Coarse rows are zeroed alongside the lowest fine rows of the sweep.
      fine_d[sweep_q] = '0;
      if (sweep_q < FRW'(CV)) coarse_d[CRW'(sweep_q)] = '0;
      if (sweep_q == '0) busy_d = 1'b0;
      else sweep_d = sweep_q - 1'b1;
    end else begin
      if (armed_q && in_range) begin
        if (SW) begin
          if (!coarse_q[CRW'(row_q)][CCW'(col_q)]) begin
            coarse_d[CRW'(row_q)][CCW'(col_q)] = 1'b1;
            coarse_cnt_d = sat_add(coarse_cnt_q, COARSE_INC);
          end
        end else begin
          if (!fine_q[FRW'(row_q)][FCW'(col_q)]) begin
            fine_d[FRW'(row_q)][FCW'(col_q)] = 1'b1;
            fine_cnt_d = sat_add(fine_cnt_q, FINE_INC);
          end
        end
      end
      if (|btn_edge[3:0]) begin
        if (!armed_q) armed_d = 1'b1;
        else if (btn_edge[0]) col_d = (col_q >= hlim - 9'd1) ? ((WRAP != 0) ? 9'd0 : col_q) : col_q + 9'd1;
        else if (btn_edge[3]) col_d = (col_q == 9'd0) ? ((WRAP != 0) ? hlim - 9'd1 : 9'd0) : col_q - 9'd1;
        else if (btn_edge[1]) row_d = (row_q >= vlim - 9'd1) ? ((WRAP != 0) ? 9'd0 : row_q) : row_q + 9'd1;
        else row_d = (row_q == 9'd0) ? ((WRAP != 0) ? vlim - 9'd1 : 9'd0) : row_q - 9'd1;
      end
      // Switching to the coarse grid can leave the cursor outside it.
      if (row_q >= vlim) row_d = vlim - 9'd1;
      if (col_q >= hlim) col_d = hlim - 9'd1;
    end
  end

  always_comb begin
    fy   = vcnt / 12'(CELL_PX);
    fx   = hcnt / 12'(CELL_PX);
    cy   = vcnt / 12'(2 * CELL_PX);
    cx   = hcnt / 12'(2 * CELL_PX);
    on_d = 1'b0;
    if (!busy_q) begin
      if (SW) begin
        if (cy < 12'(CV) && cx < 12'(CH)) on_d = coarse_q[CRW'(12'(CV - 1) - cy)][CCW'(cx)];
      end else begin
        if (fy < 12'(VSIZE) && fx < 12'(HSIZE)) on_d = fine_q[FRW'(12'(VSIZE - 1) - fy)][FCW'(fx)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    fine_q   <= fine_d;
    coarse_q <= coarse_d;
    if (RESET) begin
      prev_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b1;
      sweep_q      <= FRW'(VSIZE - 1);
      on_q         <= 1'b0;
      fine_cnt_q   <= '0;
      coarse_cnt_q <= '0;
    end else begin
      prev_q       <= PushButton;
      row_q        <= row_d;
      col_q        <= col_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      sweep_q      <= sweep_d;
      on_q         <= on_d;
      fine_cnt_q   <= fine_cnt_d;
      coarse_cnt_q <= coarse_cnt_d;
    end
  end

  assign on        = on_q;
  assign busy      = busy_q;
  assign cur_row   = row_q;
  assign cur_col   = col_q;
  assign pixel_cnt = SW ? coarse_cnt_q : fine_cnt_q;
endmodule

// File: tb/tb_paint_tracker_grid.sv
// Directed bench for paint_tracker_grid: a clamping instance and a wrapping
// instance share clock, reset and display inputs but have their own buttons.
module tb_paint_tracker_grid;
  logic        clk, rst, sw;
  logic [4:0]  pb, pb_w;
  logic [11:0] hcnt, vcnt;
  logic        on, busy, on_w, busy_w;
  logic [16:0] cnt, cnt_w;
  logic [8:0]  row, col, row_w, col_w;
  int          vecs, errs, n;

  paint_tracker_grid dut (
    .CLK(clk), .RESET(rst), .PushButton(pb), .SW(sw), .hcnt(hcnt), .vcnt(vcnt),
    .on(on), .pixel_cnt(cnt), .busy(busy), .cur_row(row), .cur_col(col)
  );

  paint_tracker_grid #(.WRAP(1)) dut_w (
    .CLK(clk), .RESET(rst), .PushButton(pb_w), .SW(sw), .hcnt(hcnt), .vcnt(vcnt),
    .on(on_w), .pixel_cnt(cnt_w), .busy(busy_w), .cur_row(row_w), .cur_col(col_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic press(input bit w, input logic [4:0] m);
    if (w) pb_w = m; else pb = m;
    step(1);
    if (w) pb_w = '0; else pb = '0;
    step(1);
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b1; pb = '0; pb_w = '0; sw = 1'b0; hcnt = '0; vcnt = '0;
    step(1);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_on", 32'(on), 0);
    chk("rst_w_busy", 32'(busy_w), 1);
    n = 0;
    while (busy && n < 200) begin n++; step(1); end
    chk("rst_busy_len", n, 54);
    vcnt = 12'd269; step(1);
    chk("rst_on_cell00", 32'(on), 0);

    // arm, then move right and up
    press(0, 5'b00001);
    chk("arm_col", 32'(col), 0);
    chk("arm_cnt", 32'(cnt), 25);
    press(0, 5'b00001);
    press(0, 5'b00010);
    chk("move_row", 32'(row), 1);
    chk("move_col", 32'(col), 1);
    chk("move_cnt", 32'(cnt), 75);
    hcnt = 12'd5; vcnt = 12'd264; step(1);
    chk("on_cell11", 32'(on), 1);
    hcnt = 12'd0; step(1);
    chk("on_cell10", 32'(on), 0);
    vcnt = 12'd270; step(1);
    chk("on_beyond", 32'(on), 0);

    // clamp at the bottom edge
    press(0, 5'b00100);
    for (int i = 0; i < 3; i++) press(0, 5'b00100);
    chk("clamp_row", 32'(row), 0);
    chk("clamp_cnt", 32'(cnt), 75);

    // right beats left; revisit adds nothing
    press(0, 5'b01001);
    chk("prio_col", 32'(col), 2);
    chk("prio_cnt", 32'(cnt), 100);
    press(0, 5'b01000);
    chk("revisit_col", 32'(col), 1);
    chk("revisit_cnt", 32'(cnt), 100);

    // walk to (40,60) then switch to the coarse grid
    for (int i = 0; i < 40; i++) press(0, 5'b00010);
    for (int i = 0; i < 59; i++) press(0, 5'b00001);
    chk("walk_row", 32'(row), 40);
    chk("walk_col", 32'(col), 60);
    chk("walk_cnt", 32'(cnt), 2550);
    sw = 1'b1; step(1);
    chk("coarse_row", 32'(row), 26);
    chk("coarse_col", 32'(col), 47);
    chk("coarse_cnt0", 32'(cnt), 0);
    step(1);
    chk("coarse_cnt", 32'(cnt), 100);
    hcnt = 12'd475; vcnt = 12'd5; step(1);
    chk("coarse_on", 32'(on), 1);
    sw = 1'b0; #1;
    chk("fine_cnt_back", 32'(cnt), 2550);
    step(1);
    chk("fine_cnt_paint", 32'(cnt), 2575);
    chk("fine_on_sel", 32'(on), 0);
    sw = 1'b1; #1;
    chk("coarse_indep", 32'(cnt), 100);
    sw = 1'b0; #1;

    // clear with directions pressed during the sweep
    hcnt = 12'd0; vcnt = 12'd269; step(1);
    chk("pre_clear_on", 32'(on), 1);
    pb = 5'b10000; step(1);
    pb = '0;
    chk("clr_busy", 32'(busy), 1);
    chk("clr_cnt", 32'(cnt), 0);
    n = 0;
    while (busy && n < 200) begin
      pb = (n % 2 == 1) ? 5'b00001 : 5'b00000;
      n++;
      step(1);
      if (n == 5) chk("busy_on", 32'(on), 0);
    end
    pb = '0; step(1);
    chk("clr_len", n, 54);
    chk("clr_row", 32'(row), 0);
    chk("clr_col", 32'(col), 0);
    chk("clr_cnt_after", 32'(cnt), 0);
    sw = 1'b1; #1;
    chk("clr_coarse_cnt", 32'(cnt), 0);
    sw = 1'b0; #1;
    press(0, 5'b00001);
    chk("rearm_col", 32'(col), 0);
    chk("rearm_cnt", 32'(cnt), 25);

    // clear again at sweep cycle 20
    pb = 5'b10000; step(1);
    pb = '0; step(19);
    chk("mid_busy", 32'(busy), 1);
    pb = 5'b10000; step(1);
    pb = '0;
    n = 0;
    while (busy && n < 200) begin n++; step(1); end
    chk("restart_len", n, 54);
    chk("restart_cnt", 32'(cnt), 0);

    // wrapping instance
    press(1, 5'b00010);
    chk("w_arm_row", 32'(row_w), 0);
    chk("w_arm_cnt", 32'(cnt_w), 25);
    press(1, 5'b01000);
    chk("w_left_col", 32'(col_w), 95);
    chk("w_left_cnt", 32'(cnt_w), 50);
    press(1, 5'b00010);
    press(1, 5'b00001);
    chk("w_right_col", 32'(col_w), 0);
    chk("w_right_cnt", 32'(cnt_w), 100);
    press(1, 5'b00100);
    press(1, 5'b00100);
    chk("w_down_row", 32'(row_w), 53);
    chk("w_down_cnt", 32'(cnt_w), 125);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
